// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_iter
//  Purpose  : Iterative ALU. Single-cycle arithmetic, logic and shift ops;
//             radix-2 multi-cycle multiply and unsigned/signed divide.
//             Valid/ready handshakes on both the request and result sides.
//  Revision : 1.0  initial release
// ============================================================================
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag_q
);

  // Command encodings shared with the instruction decoder.
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB1 = 5'd2;
  localparam logic [4:0] OP_SUB2 = 5'd3;
  localparam logic [4:0] OP_SBC  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_MOV  = 5'd8;
  localparam logic [4:0] OP_INC  = 5'd9;
  localparam logic [4:0] OP_DEC  = 5'd10;
  localparam logic [4:0] OP_ZERO = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;
  localparam logic [4:0] OP_LSL  = 5'd13;
  localparam logic [4:0] OP_LSR  = 5'd14;
  localparam logic [4:0] OP_ASR  = 5'd15;
  localparam logic [4:0] OP_ROR  = 5'd16;
  localparam logic [4:0] OP_BIC  = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;
  localparam logic [4:0] OP_UDIV = 5'd19;
  localparam logic [4:0] OP_SDIV = 5'd20;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic          accept;
  logic          is_iter;
  logic          last_iter;
  logic [CW-1:0] iter_cnt;

  // Iteration registers: multiplicand/dividend-quotient, multiplier/divisor,
  // product accumulator/partial remainder.
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] a_next, b_next, acc_next;
  logic             mul_q, neg_q, dz_q;
  logic [1:0]       cv_q;

  // Single-cycle datapath signals
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic [SHW-1:0]   shamt;
  logic             shamt_zero;
  logic [WIDTH:0]   lsl_ext, lsr_ext, asr_ext;
  logic signed [WIDTH:0] asr_src;
  logic [31:0]      rot_amt;
  logic [WIDTH-1:0] ror_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;

  // Divide helpers
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] fin_res;
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_mag, op2_mag;

  // Incoming N and Z are always recomputed from the result, never consumed.
  logic unused_flag_nz;
  assign unused_flag_nz = ^flag[3:2];

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  assign is_iter   = (opcode == OP_MUL) | (opcode == OP_UDIV) | (opcode == OP_SDIV);
  assign accept    = in_valid & in_ready;
  assign last_iter = (state == BUSY) && (iter_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = is_iter ? BUSY : DONE;
      end
      BUSY: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) state_next = is_iter ? BUSY : DONE;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Adder operand selection; subtraction is x + ~y + 1 so C is not-borrow.
  always_comb begin
    add_x   = op1;
    add_y   = op2;
    add_cin = 1'b0;
    case (opcode)
      OP_ADC:  add_cin = flag[1];
      OP_SUB1: begin add_y = ~op2; add_cin = 1'b1; end
      OP_SUB2: begin add_x = op2; add_y = ~op1; add_cin = 1'b1; end
      OP_SBC:  begin add_y = ~op2; add_cin = flag[1]; end
      OP_INC:  begin add_y = '0; add_cin = 1'b1; end
      OP_DEC:  begin add_y = '1; add_cin = 1'b0; end
      default: ;
    endcase
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
  end

  // Shifters; one extra bit on each extended vector catches the last bit out.
  always_comb begin
    shamt      = op2[SHW-1:0];
    shamt_zero = (shamt == '0);
    lsl_ext    = {1'b0, op1} << shamt;
    lsr_ext    = {op1, 1'b0} >> shamt;
    asr_src    = {op1, 1'b0};
    asr_ext    = asr_src >>> shamt;
    rot_amt    = 32'(shamt) % 32'(WIDTH);
    ror_res    = (op1 >> rot_amt) | (op1 << (32'(WIDTH) - rot_amt));
  end

  // Single-cycle result and C/V selection; undefined opcodes act as ZERO.
  always_comb begin
    alu_res = '0;
    alu_c   = flag[1];
    alu_v   = flag[0];
    case (opcode)
      OP_ADD, OP_ADC, OP_SUB1, OP_SUB2, OP_SBC, OP_INC, OP_DEC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_v;
      end
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_MOV:  alu_res = op2;
      OP_ZERO: alu_res = '0;
      OP_NOT:  alu_res = ~op1;
      OP_BIC:  alu_res = op1 & ~op2;
      OP_LSL: begin
        alu_res = lsl_ext[WIDTH-1:0];
        if (!shamt_zero) alu_c = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_ext[WIDTH:1];
        if (!shamt_zero) alu_c = lsr_ext[0];
      end
      OP_ASR: begin
        alu_res = asr_ext[WIDTH:1];
        if (!shamt_zero) alu_c = asr_ext[0];
      end
      OP_ROR: begin
        alu_res = ror_res;
        if (!shamt_zero) alu_c = ror_res[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Operand magnitudes for signed divide; quotient sign is fixed at the end.
  always_comb begin
    op1_neg = (opcode == OP_SDIV) & op1[WIDTH-1];
    op2_neg = (opcode == OP_SDIV) & op2[WIDTH-1];
    op1_mag = op1_neg ? -op1 : op1;
    op2_mag = op2_neg ? -op2 : op2;
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    rem_sh = {acc_q, a_q[WIDTH-1]};
    rem_ge = (rem_sh >= {1'b0, b_q});
    if (mul_q) begin
      acc_next = acc_q + (b_q[0] ? a_q : '0);
      a_next   = a_q << 1;
      b_next   = b_q >> 1;
    end else begin
      b_next = b_q;
      if (rem_ge) begin
        acc_next = rem_sh[WIDTH-1:0] - b_q;
        a_next   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = rem_sh[WIDTH-1:0];
        a_next   = {a_q[WIDTH-2:0], 1'b0};
      end
    end
    quo_signed = neg_q ? -a_next : a_next;
    // Divide by zero yields 0; most-negative / -1 wraps back to most-negative.
    fin_res    = mul_q ? acc_next : (dz_q ? '0 : quo_signed);
  end

  // Operand capture, iteration and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mul_q    <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      cv_q     <= 2'b00;
      result   <= '0;
      flag_q   <= 4'h0;
    end else if (accept) begin
      iter_cnt <= '0;
      cv_q     <= flag[1:0];
      if (is_iter) begin
        mul_q <= (opcode == OP_MUL);
        neg_q <= op1_neg ^ op2_neg;
        dz_q  <= (op2 == '0);
        acc_q <= '0;
        if (opcode == OP_MUL) begin
          a_q <= op1;
          b_q <= op2;
        end else begin
          a_q <= op1_mag;
          b_q <= op2_mag;
        end
      end else begin
        result <= alu_res;
        flag_q <= pack_flags(alu_res, alu_c, alu_v);
      end
    end else if (state == BUSY) begin
      iter_cnt <= iter_cnt + CW'(1);
      a_q      <= a_next;
      b_q      <= b_next;
      acc_q    <= acc_next;
      if (last_iter) begin
        result <= fin_res;
        flag_q <= pack_flags(fin_res, cv_q[1], cv_q[0]);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_iter
//  Purpose  : Scoreboard bench for alu_iter: directed corner vectors, stall,
//             reset-during-divide and randomized traffic against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_iter;

  localparam int W = 32;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB1 = 5'd2;
  localparam logic [4:0] OP_SUB2 = 5'd3;
  localparam logic [4:0] OP_SBC  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_MOV  = 5'd8;
  localparam logic [4:0] OP_INC  = 5'd9;
  localparam logic [4:0] OP_DEC  = 5'd10;
  localparam logic [4:0] OP_ZERO = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;
  localparam logic [4:0] OP_LSL  = 5'd13;
  localparam logic [4:0] OP_LSR  = 5'd14;
  localparam logic [4:0] OP_ASR  = 5'd15;
  localparam logic [4:0] OP_ROR  = 5'd16;
  localparam logic [4:0] OP_BIC  = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;
  localparam logic [4:0] OP_UDIV = 5'd19;
  localparam logic [4:0] OP_SDIV = 5'd20;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]   opcode;
  logic [W-1:0] op1, op2, result;
  logic [3:0]   flag, flag_q;

  alu_iter #(.WIDTH(W), .SHW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .op1(op1), .op2(op2), .flag(flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_q(flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  bit   head_seen = 0;
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ovf(input longint x);
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  // Reference: plain integer arithmetic and bit-at-a-time shifting.
  function automatic logic [35:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [3:0] f);
    logic [31:0] r;
    logic        c, v, bor;
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    int          s;
    c = f[1]; v = f[0]; r = '0;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    s  = int'(b[7:0]);
    bor = ~f[1];
    case (op)
      OP_ADD:  begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; v = ovf(sa + sb); end
      OP_ADC:  begin r = a + b + 32'(f[1]); c = (ua + ub + 64'(f[1])) > 64'hFFFF_FFFF;
                     v = ovf(sa + sb + longint'(f[1])); end
      OP_SUB1: begin r = a - b; c = ua >= ub; v = ovf(sa - sb); end
      OP_SUB2: begin r = b - a; c = ub >= ua; v = ovf(sb - sa); end
      OP_SBC:  begin r = a - b - 32'(bor); c = ua >= (ub + 64'(bor));
                     v = ovf(sa - sb - longint'(bor)); end
      OP_INC:  begin r = a + 1; c = (ua + 1) > 64'hFFFF_FFFF; v = ovf(sa + 1); end
      OP_DEC:  begin r = a - 1; c = ua >= 1; v = ovf(sa - 1); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MOV:  r = b;
      OP_ZERO: r = '0;
      OP_NOT:  r = ~a;
      OP_BIC:  r = a & ~b;
      OP_LSL:  begin r = a; for (int i = 0; i < s; i++) begin c = r[31]; r = r << 1; end end
      OP_LSR:  begin r = a; for (int i = 0; i < s; i++) begin c = r[0]; r = r >> 1; end end
      OP_ASR:  begin r = a; for (int i = 0; i < s; i++) begin c = r[0]; r = {r[31], r[31:1]}; end end
      OP_ROR:  begin r = a; for (int i = 0; i < s; i++) begin c = r[0]; r = {r[0], r[31:1]}; end end
      OP_MUL:  begin p = ua * ub; r = p[31:0]; end
      OP_UDIV: r = (b == 0) ? 32'h0 : a / b;
      OP_SDIV: begin
        if (b == 0) r = '0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(sa / sb);
      end
      default: r = '0;
    endcase
    return {r, r[31], (r == 0), c, v};
  endfunction

  function automatic bit iter_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_UDIV) || (op == OP_SDIV);
  endfunction

  // Monitor: compares every presented result against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        if (!head_seen) begin
          chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
          head_seen = 1;
        end
        chk("result", 64'(result), 64'(sbq[0].res));
        chk("flag_q", 64'(flag_q), 64'(sbq[0].flg));
        if (out_ready) begin
          void'(sbq.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  // Present one request; called at posedge+1. Returns cycles waited for accept.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] f, input bit use_exp, input logic [31:0] eres,
                      input logic [3:0] eflg, input bit rand_ready, output int waited);
    logic [35:0] m;
    exp_t        e;
    int          acc_cyc;
    bit          ok;
    in_valid = 1'b1; opcode = op; op1 = a; op2 = b; flag = f;
    ok = 0; waited = 0; acc_cyc = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      acc_cyc = cyc;
      ok = in_ready;
      @(posedge clk); #1;
      if (!ok) begin
        waited++;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    in_valid = 1'b0;
    opcode = 5'($urandom); op1 = $urandom; op2 = $urandom; flag = 4'($urandom);
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: in_ready never seen, op %0d", op);
    end else begin
      m     = ref_model(op, a, b, f);
      e.res = use_exp ? eres : m[35:4];
      e.flg = use_exp ? eflg : m[3:0];
      e.lat = iter_op(op) ? W + 1 : 1;
      e.acc = acc_cyc;
      sbq.push_back(e);
    end
  endtask

  function automatic logic [31:0] pick_operand(input bit shift_amt);
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return shift_amt ? 32'($urandom_range(0, 70)) : 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sbq.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: %0d results outstanding", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [4:0] rop;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; op1 = '0; op2 = '0; flag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flag_q", 64'(flag_q), 64'd0);
    @(posedge clk); #1;

    // Directed corner vectors with literal expectations
    send(OP_ADD,  32'h7FFF_FFFF, 32'h1, 4'h0, 1, 32'h8000_0000, 4'b1001, 0, w);
    send(OP_SUB1, 32'd5, 32'd5, 4'h0, 1, 32'h0, 4'b0110, 0, w);
    send(OP_LSR,  32'h8000_0001, 32'd1, 4'h0, 1, 32'h4000_0000, 4'b0010, 0, w);
    send(OP_LSL,  32'h1234_5678, 32'd40, 4'b0011, 1, 32'h0, 4'b0101, 0, w);
    send(OP_ASR,  32'h8000_0000, 32'd100, 4'h0, 1, 32'hFFFF_FFFF, 4'b1010, 0, w);
    send(OP_ROR,  32'h1, 32'd33, 4'h0, 1, 32'h8000_0000, 4'b1010, 0, w);
    send(5'd31,   32'hDEAD_BEEF, 32'h1, 4'b0011, 1, 32'h0, 4'b0111, 0, w);
    drain();

    // Multiply with in_ready checked low for every BUSY cycle
    send(OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, 4'h0, 1, 32'hFFFE_0001, 4'b1000, 0, w);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("in_ready_busy", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    send(OP_UDIV, 32'd100, 32'd7, 4'h0, 1, 32'd14, 4'b0000, 0, w);
    send(OP_SDIV, 32'hFFFF_FFF9, 32'd2, 4'h0, 1, 32'hFFFF_FFFD, 4'b1000, 0, w);
    send(OP_UDIV, 32'd9, 32'd0, 4'h0, 1, 32'h0, 4'b0100, 0, w);
    send(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0001, 1, 32'h8000_0000, 4'b1001, 0, w);
    drain();

    // Stall in DONE for 5 cycles, then release with a simultaneous request
    out_ready = 1'b0;
    send(OP_XOR, 32'hF0F0_0000, 32'h0F0F_0001, 4'h0, 1, 32'hFFFF_0001, 4'b1000, 0, w);
    repeat (5) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(OP_SUB1, 32'd5, 32'd5, 4'h0, 1, 32'h0, 4'b0110, 0, w);
    chk("same_cycle_accept", 64'(w), 64'd0);
    drain();

    // Reset pulsed on cycle 10 of a signed divide
    send(OP_SDIV, 32'hFFFF_FF9C, 32'd3, 4'h0, 0, 32'h0, 4'h0, 0, w);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sbq.delete();
    head_seen = 0;
    #2;
    chk("midop_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midop_rst_result", 64'(result), 64'd0);
    chk("midop_rst_flag_q", 64'(flag_q), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(OP_ADD, 32'd2, 32'd3, 4'h0, 1, 32'd5, 4'b0000, 0, w);
    drain();

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 300; n++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = pick_operand(0);
      rb  = pick_operand(rop >= OP_LSL && rop <= OP_ROR);
      if ((rop == OP_UDIV || rop == OP_SDIV) && $urandom_range(0, 5) == 0) rb = 32'h0;
      send(rop, ra, rb, 4'($urandom), 0, 32'h0, 4'h0, 1, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 8..64, even.
REQ-002 Parameter SHW, default 8, width of shift-amount field taken from op2[SHW-1:0].
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  request presented.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opcode  input  5  operation select, encodings from the shared command-definition include; MUL_IT, UDIV_OP, SDIV_OP added there.
REQ-008 op1, op2  input  WIDTH  operands.
REQ-009 flag  input  4  incoming N,Z,C,V (bits 3..0).
REQ-010 out_valid  output  1  result and flag_q valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 flag_q  output  4  registered N,Z,C,V.

Function
REQ-014 Request accepted when in_valid & in_ready; opcode, op1, op2 and flag are captured at acceptance and inputs are ignored afterwards.
REQ-015 FSM states IDLE, BUSY, DONE; IDLE->DONE for single-cycle ops, IDLE->BUSY for MUL_IT/UDIV_OP/SDIV_OP, BUSY->DONE when the iteration count reaches WIDTH, DONE->IDLE on out_ready without a new accept, DONE->DONE or DONE->BUSY on out_ready with a simultaneous accept.
REQ-016 in_ready = (state==IDLE) | (state==DONE & out_ready); out_valid = (state==DONE).
REQ-017 Single-cycle ops (ADD, ADC, SUB1, SUB2, SBC, AND, OR, XOR, MOV, INC, DEC, ZERO, NOT, LSL, LSR, ASR, ROR, BIC): out_valid asserted the cycle after acceptance.
REQ-018 Iterative ops: radix-2, one bit per cycle, WIDTH cycles in BUSY; out_valid asserted WIDTH+1 cycles after acceptance.
REQ-019 MUL_IT returns low WIDTH bits of the unsigned product.
REQ-020 UDIV_OP returns unsigned quotient; SDIV_OP returns signed quotient truncated toward zero.
REQ-021 Divide by zero returns 0; SDIV of most-negative by -1 returns most-negative; neither case raises an error.
REQ-022 Add/sub ops use a WIDTH+1-bit intermediate; C = carry-out for add, not-borrow for sub; V = signed overflow of the WIDTH-bit operation.
REQ-023 Shift amount s = op2[SHW-1:0]; LSL/LSR with s>=WIDTH give 0; ASR with s>=WIDTH gives all sign bits; ROR uses s mod WIDTH.
REQ-024 Shifts with s!=0 set C to the last bit shifted out (for s>WIDTH on LSL/LSR, C=0; for ASR, C=sign bit); with s==0, C is the incoming flag[1].
REQ-025 N = result[WIDTH-1] and Z = (result==0) for every op; C and V are the captured flag bits for all ops not covered by REQ-022/024.
REQ-026 result and flag_q hold stable while out_valid & !out_ready.
REQ-027 Undefined opcode behaves as ZERO with C,V preserved.

Reset
REQ-028 rst asserted at any time, including mid-iteration, forces IDLE, iteration counter 0, result 0, flag_q 0, out_valid 0; the in-flight operation is discarded.
REQ-029 in_ready is 1 on the first clock edge after rst deasserts.

Verification
REQ-030 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, flag_q N=1 Z=0 C=0 V=1, out_valid exactly 1 cycle after accept.
REQ-031 SUB1 5-5 -> result 0, Z=1 C=1 V=0; LSR 0x80000001 by 1 -> 0x40000000, C=1; LSL by 40 -> 0, C=0.
REQ-032 MUL_IT 0x0000FFFF * 0x0000FFFF -> 0xFFFE0001, out_valid 33 cycles after accept, in_ready 0 throughout BUSY.
REQ-033 UDIV 100/7 -> 14; SDIV -7/2 -> 0xFFFFFFFD; UDIV 9/0 -> 0, Z=1.
REQ-034 out_ready held 0 for 5 cycles in DONE -> result/flag_q unchanged; then out_ready=1 with in_valid=1 -> new request accepted same cycle, next result 1 cycle later.
REQ-035 rst pulsed on cycle 10 of an SDIV -> out_valid 0, result 0, in_ready 1 after release; a following ADD 2+3 returns 5.
